gmac_rx_fcs_check: RTL and testbench



---
 rtl/gmac_rx_fcs_check.sv | 118 +++++++++++
 tb/tb_gmac_rx_fcs_check.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmac_rx_fcs_check.sv
// gmac_rx_fcs_check: receive-side CRC-32 residue check and FCS strip for one Ethernet frame at a time.
// Revision: 1.0 - initial release
`default_nettype none

module gmac_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_err,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        stat_valid,
  output logic        stat_good,
  output logic        stat_crc_err,
  output logic        stat_runt,
  output logic        stat_long,
  output logic        stat_err,
  output logic [15:0] stat_len
);

  localparam logic [31:0] c_poly    = 32'hEDB8_8320;
  localparam logic [31:0] c_residue = 32'hDEBB_20E3;
  localparam logic [2:0]  c_full    = 3'd4;

  logic [31:0] r_crc;
  logic [15:0] r_len;
  logic [2:0]  r_fill;
  logic        r_err_seen;
  // Four-byte delay line: [7:0] newest, [31:24] oldest.
  logic [31:0] r_sr;

  logic [31:0] w_crc_next;
  logic [15:0] w_len_next;
  logic        w_err;
  logic        w_crc_ok;
  logic        w_runt;
  logic        w_long;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ c_poly) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    w_crc_next = crc_byte(r_crc, in_data);
    w_len_next = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
    w_err      = r_err_seen | in_err;
    w_crc_ok   = (w_crc_next == c_residue);
    w_runt     = 32'(w_len_next) < MIN_LEN;
    w_long     = 32'(w_len_next) > MAX_LEN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc        <= '1;
      r_len        <= '0;
      r_fill       <= '0;
      r_err_seen   <= 1'b0;
      r_sr         <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      stat_valid   <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_runt    <= 1'b0;
      stat_long    <= 1'b0;
      stat_err     <= 1'b0;
      stat_len     <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      stat_valid <= 1'b0;
      if (in_valid) begin
        r_sr <= {r_sr[23:0], in_data};
        if (r_fill == c_full) begin
          out_valid <= 1'b1;
          out_data  <= r_sr[31:24];
          out_last  <= in_last;
        end
        // The closing byte reports status and rearms state for the next frame.
        if (in_last) begin
          r_crc        <= '1;
          r_len        <= '0;
          r_fill       <= '0;
          r_err_seen   <= 1'b0;
          stat_valid   <= 1'b1;
          stat_good    <= w_crc_ok & ~w_runt & ~w_long & ~w_err;
          stat_crc_err <= ~w_crc_ok;
          stat_runt    <= w_runt;
          stat_long    <= w_long;
          stat_err     <= w_err;
          stat_len     <= w_len_next;
        end else begin
          r_crc      <= w_crc_next;
          r_len      <= w_len_next;
          r_err_seen <= w_err;
          if (r_fill != c_full) begin
            r_fill <= r_fill + 3'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gmac_rx_fcs_check.sv
// tb_gmac_rx_fcs_check: directed bench for gmac_rx_fcs_check with default and relaxed-limit instances.
// Revision: 1.0 - initial release
`default_nettype none
`timescale 1ns/1ps

module tb_gmac_rx_fcs_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_err;

  logic        d_out_valid, d_out_last, d_stat_valid, d_stat_good, d_stat_crc_err;
  logic        d_stat_runt, d_stat_long, d_stat_err;
  logic [7:0]  d_out_data;
  logic [15:0] d_stat_len;
  logic        z_out_valid, z_out_last, z_stat_valid, z_stat_good, z_stat_crc_err;
  logic        z_stat_runt, z_stat_long, z_stat_err;
  logic [7:0]  z_out_data;
  logic [15:0] z_stat_len;

  gmac_rx_fcs_check dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_last(d_out_last),
    .stat_valid(d_stat_valid), .stat_good(d_stat_good), .stat_crc_err(d_stat_crc_err),
    .stat_runt(d_stat_runt), .stat_long(d_stat_long), .stat_err(d_stat_err), .stat_len(d_stat_len)
  );

  // Relaxed instance: no runt limit, and MAX_LEN sits exactly on the 13-byte test frame.
  gmac_rx_fcs_check #(.MIN_LEN(0), .MAX_LEN(13)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .out_valid(z_out_valid), .out_data(z_out_data), .out_last(z_out_last),
    .stat_valid(z_stat_valid), .stat_good(z_stat_good), .stat_crc_err(z_stat_crc_err),
    .stat_runt(z_stat_runt), .stat_long(z_stat_long), .stat_err(z_stat_err), .stat_len(z_stat_len)
  );

  typedef struct packed {
    logic        good;
    logic        crc_err;
    logic        runt;
    logic        lng;
    logic        err;
    logic [15:0] len;
  } stat_t;

  stat_t      st_q[$];
  stat_t      st0_q[$];
  logic [7:0] pay_q[$];
  int         last_q[$];
  logic [7:0] fr[$];
  int         spurious = 0;
  int         nocoinc  = 0;
  logic       acc_d    = 1'b0;
  stat_t      s_mon;
  stat_t      s_mon0;
  int         total = 0;
  int         bad   = 0;

  always @(posedge clk) acc_d <= in_valid & ~rst;

  always @(negedge clk) begin
    if (d_out_valid) begin
      pay_q.push_back(d_out_data);
      if (d_out_last) last_q.push_back(pay_q.size() - 1);
      if (!acc_d) spurious++;
    end
    if (d_out_last && !d_out_valid) spurious++;
    if (d_out_last && !d_stat_valid) nocoinc++;
    if (d_stat_valid) begin
      s_mon = '{d_stat_good, d_stat_crc_err, d_stat_runt, d_stat_long, d_stat_err, d_stat_len};
      st_q.push_back(s_mon);
      if (!acc_d) spurious++;
    end
    if (z_stat_valid) begin
      s_mon0 = '{z_stat_good, z_stat_crc_err, z_stat_runt, z_stat_long, z_stat_err, z_stat_len};
      st0_q.push_back(s_mon0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = {1'b0, r[31:1]} ^ 32'hEDB88320;
      else             r = {1'b0, r[31:1]};
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_digits(input logic [7:0] last_fcs);
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, last_fcs};
  endtask

  task automatic build_good(input int n, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    fr.delete();
    for (int i = 0; i < n; i++) begin
      fr.push_back(8'((i * 7 + seed) & 8'hFF));
      c = ref_crc(c, fr[i]);
    end
    c = ~c;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  // Sends fr[0..nbytes-1]; in_last on the final queue byte and on mid_last; 3-cycle gaps before g0/g1/g2.
  task automatic drive(input int nbytes, input int mid_last, input int err_at,
                       input int g0, input int g1, input int g2);
    for (int i = 0; i < nbytes; i++) begin
      if (i == g0 || i == g1 || i == g2) begin
        in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
        idle(3);
      end
      in_valid = 1'b1;
      in_data  = fr[i];
      in_last  = (i == fr.size() - 1) || (i == mid_last);
      in_err   = (i == err_at);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
  endtask

  task automatic chk_payload(input string tag, input int base, input int lbase, input int n, input int off);
    chk({tag, "_count"}, 32'(pay_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      if (base + i < pay_q.size()) chk({tag, "_byte"}, 32'(pay_q[base + i]), 32'(fr[off + i]));
    chk({tag, "_lastcnt"}, 32'(last_q.size() - lbase), (n > 0) ? 32'd1 : 32'd0);
    if (n > 0 && last_q.size() > lbase) chk({tag, "_lastpos"}, 32'(last_q[lbase]), 32'(base + n - 1));
  endtask

  task automatic chk_stat(input string tag, input stat_t s, input logic good, input logic crc_err,
                          input logic runt, input logic lng, input logic err, input logic [15:0] len);
    chk({tag, "_good"},    32'(s.good),    32'(good));
    chk({tag, "_crc_err"}, 32'(s.crc_err), 32'(crc_err));
    chk({tag, "_runt"},    32'(s.runt),    32'(runt));
    chk({tag, "_long"},    32'(s.lng),     32'(lng));
    chk({tag, "_err"},     32'(s.err),     32'(err));
    chk({tag, "_len"},     32'(s.len),     32'(len));
  endtask

  int pb, lb, sb, sb0;

  task automatic mark();
    pb = pay_q.size(); lb = last_q.size(); sb = st_q.size(); sb0 = st0_q.size();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_err = 1'b0;
    idle(3);
    chk("rst_out_valid",  32'(d_out_valid),  32'd0);
    chk("rst_out_last",   32'(d_out_last),   32'd0);
    chk("rst_out_data",   32'(d_out_data),   32'd0);
    chk("rst_stat_valid", 32'(d_stat_valid), 32'd0);
    chk("rst_stat_good",  32'(d_stat_good),  32'd0);
    chk("rst_stat_len",   32'(d_stat_len),   32'd0);
    rst = 1'b0;
    idle(2);

    // 13-byte "123456789" frame with correct FCS
    set_digits(8'hCB); mark();
    drive(fr.size(), -1, -1, -1, -1, -1); idle(3);
    chk_payload("f13", pb, lb, 9, 0);
    chk("f13_nstat", 32'(st_q.size() - sb), 32'd1);
    chk("f13_nstat0", 32'(st0_q.size() - sb0), 32'd1);
    if (st_q.size() > sb)   chk_stat("f13_dflt", st_q[sb],   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd13);
    if (st0_q.size() > sb0) chk_stat("f13_min0", st0_q[sb0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd13);

    // Same frame, corrupted final FCS byte
    set_digits(8'hCA); mark();
    drive(fr.size(), -1, -1, -1, -1, -1); idle(3);
    chk_payload("bad13", pb, lb, 9, 0);
    if (st0_q.size() > sb0) chk_stat("bad13_min0", st0_q[sb0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd13);

    // Minimum-length legal frame
    build_good(60, 3); mark();
    drive(fr.size(), -1, -1, -1, -1, -1); idle(3);
    chk_payload("f64", pb, lb, 60, 0);
    if (st_q.size() > sb)   chk_stat("f64_dflt", st_q[sb],   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64);
    if (st0_q.size() > sb0) chk_stat("f64_min0", st0_q[sb0], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd64);

    // Same frame with three idle gaps
    mark();
    drive(fr.size(), -1, -1, 5, 27, 50); idle(3);
    chk_payload("gap", pb, lb, 60, 0);
    if (st_q.size() > sb) chk_stat("gap_dflt", st_q[sb], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64);
    chk("gap_spurious", 32'(spurious), 32'd0);

    // 3-byte runt immediately followed by the good 13-byte frame
    set_digits(8'hCB);
    fr.push_front(8'hCC); fr.push_front(8'hBB); fr.push_front(8'hAA);
    mark();
    drive(fr.size(), 2, -1, -1, -1, -1); idle(3);
    chk_payload("b2b", pb, lb, 9, 3);
    chk("b2b_nstat", 32'(st_q.size() - sb), 32'd2);
    if (st_q.size() > sb) begin
      chk("b2b_runt_len",  32'(st_q[sb].len),  32'd3);
      chk("b2b_runt_runt", 32'(st_q[sb].runt), 32'd1);
      chk("b2b_runt_good", 32'(st_q[sb].good), 32'd0);
    end
    if (st0_q.size() > sb0 + 1) chk_stat("b2b_second", st0_q[sb0 + 1], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd13);

    // Reset after the 20th byte, then a clean frame
    build_good(60, 11); mark();
    drive(20, -1, -1, -1, -1, -1);
    rst = 1'b1; #1;
    chk("mid_rst_out_valid",  32'(d_out_valid),  32'd0);
    chk("mid_rst_out_data",   32'(d_out_data),   32'd0);
    chk("mid_rst_stat_valid", 32'(d_stat_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    chk("mid_rst_nostat", 32'(st_q.size() - sb), 32'd0);
    mark();
    drive(fr.size(), -1, -1, -1, -1, -1); idle(3);
    chk_payload("post_rst", pb, lb, 60, 0);
    if (st_q.size() > sb) chk_stat("post_rst", st_q[sb], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64);

    // in_err on byte 10 of an otherwise valid frame
    mark();
    drive(fr.size(), -1, 9, -1, -1, -1); idle(3);
    chk_payload("err", pb, lb, 60, 0);
    if (st_q.size() > sb) chk_stat("err", st_q[sb], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd64);

    chk("spurious_total", 32'(spurious), 32'd0);
    chk("last_vs_stat",   32'(nocoinc),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
